frnd_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one float-to-integer rounding unit among NUM_REQ requesters (e.g. ALU lanes, coprocessor issue ports). It accepts one single-precision operand per grant, drives the unit's execute/operand inputs, and waits the unit's fixed latency. It then captures the rounded integer and returns it to the granted requester over a valid/ready response channel. Only one conversion is in flight at a time.

---
 rtl/frnd_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_frnd_arbiter.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frnd_arbiter.sv
// -----------------------------------------------------------------------------
// frnd_arbiter
//
// Round-robin arbiter/sequencer sharing one float-to-integer rounding unit
// among NUM_REQ requesters. One conversion is in flight at a time: the
// granted operand is launched into the unit with unit_execute. The result
// is captured UNIT_LATENCY cycles later. It is then held on a one-hot
// valid/ready response channel until the granted requester accepts it.
//
// Ports
//   clk           clock, all state on the rising edge
//   reset         synchronous active-high reset; forces every output to 0
//   req_valid     per-requester request valid
//   req_data      32-bit IEEE-754 operand per requester, requester i at [32i+31:32i]
//   req_ready     one-hot grant/accept strobe (combinational, IDLE only)
//   resp_valid    one-hot response valid for the granted requester
//   resp_data     rounded two's-complement integer, held while resp_valid
//   resp_ready    per-requester response accept (only the granted bit matters)
//   unit_execute  start strobe to the rounding unit (grant cycle only)
//   unit_in       operand to the rounding unit (0 when not executing)
//   unit_out      result from the rounding unit
//   busy          high whenever the sequencer is not idle
//   grant_cnt     (FRND_ARB_STATS_EN only) 16-bit saturating grant counter
//                 per requester, requester i at [16i+15:16i]
//
// Build option
//   FRND_ARB_STATS_EN  adds the grant_cnt output and its counters.
// -----------------------------------------------------------------------------
module frnd_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int UNIT_LATENCY = 3,
  parameter int IDX_W        = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [31:0]             resp_data,
  input  logic [NUM_REQ-1:0]      resp_ready,
  output logic                    unit_execute,
  output logic [31:0]             unit_in,
  input  logic [31:0]             unit_out,
  output logic                    busy
`ifdef FRND_ARB_STATS_EN
  ,
  output logic [16*NUM_REQ-1:0]   grant_cnt
`endif
);

  localparam int CNT_W = $clog2(UNIT_LATENCY + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state_q,     state_d;
  logic [IDX_W-1:0] rr_ptr_q,    rr_ptr_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [CNT_W-1:0] wait_cnt_q,  wait_cnt_d;
  logic [31:0]      resp_data_q, resp_data_d;

  logic             grant_found;
  logic [IDX_W-1:0] grant_sel;
  logic [IDX_W-1:0] cand;
  logic             grant_now;

  // Round-robin search starting at rr_ptr+1. The scan runs from the farthest
  // candidate to the nearest so the last hit, i.e. the nearest valid
  // requester after the pointer, wins.
  // NOTE: every signal written in an always_comb gets a default at the top;
  // a path that leaves one unassigned would otherwise infer a latch.
  always_comb begin
    grant_found = 1'b0;
    grant_sel   = '0;
    cand        = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = IDX_W'((int'(rr_ptr_q) + off) % NUM_REQ);
      if (req_valid[cand]) begin
        grant_found = 1'b1;
        grant_sel   = cand;
      end
    end
  end

  // A grant only happens out of IDLE, and never while reset is asserted,
  // so the unit cannot see a start strobe during or before reset.
  assign grant_now = grant_found && (state_q == ST_IDLE) && !reset;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    wait_cnt_d  = wait_cnt_q;
    resp_data_d = resp_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          state_d     = ST_WAIT;
          grant_idx_d = grant_sel;
          rr_ptr_d    = grant_sel;
          wait_cnt_d  = CNT_W'(1);
        end
      end
      ST_WAIT: begin
        // The counter reaches UNIT_LATENCY in the cycle the unit result is
        // stable, so capture there rather than one cycle later.
        if (wait_cnt_q == CNT_W'(UNIT_LATENCY)) begin
          resp_data_d = unit_out;
          state_d     = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready[grant_idx_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
      grant_idx_q <= '0;
      wait_cnt_q  <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      wait_cnt_q  <= wait_cnt_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Outputs are gated with reset so they read 0 from the moment reset rises,
  // not only after the first clock edge has cleared the state.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    if (grant_now) begin
      req_ready[grant_sel] = 1'b1;
    end
    if (!reset && (state_q == ST_RESP)) begin
      resp_valid[grant_idx_q] = 1'b1;
    end
  end

  assign unit_execute = grant_now;
  assign unit_in      = grant_now ? req_data[{grant_sel, 5'd0} +: 32] : 32'h0;
  assign resp_data    = reset ? 32'h0 : resp_data_q;
  assign busy         = !reset && (state_q != ST_IDLE);

`ifdef FRND_ARB_STATS_EN
  logic [15:0] grant_cnt_q [NUM_REQ];

  // NOTE: this counter array is explicitly reset element by element; it is a
  // handful of flops, not a RAM, and software expects it to read 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        grant_cnt_q[i] <= '0;
      end
    end else if (grant_now && (grant_cnt_q[grant_sel] != 16'hFFFF)) begin
      grant_cnt_q[grant_sel] <= grant_cnt_q[grant_sel] + 16'd1;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt_out
    assign grant_cnt[16*gi +: 16] = reset ? 16'h0 : grant_cnt_q[gi];
  end
`endif

endmodule

// File: tb/tb_frnd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_frnd_arbiter
//
// Bench for frnd_arbiter with a behavioural rounding unit (round to nearest
// even, saturating, fixed latency, result present only in its valid cycle).
// Directed scenarios plus a randomized run against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_frnd_arbiter;

  localparam int NUM_REQ = 4;
  localparam int L       = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [31:0]           req_word [NUM_REQ];
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [31:0]           resp_data;
  logic [NUM_REQ-1:0]    resp_ready;
  logic                  unit_execute;
  logic [31:0]           unit_in;
  logic [31:0]           unit_out;
  logic                  busy;
`ifdef FRND_ARB_STATS_EN
  logic [16*NUM_REQ-1:0] grant_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pack
    assign req_data[32*gi +: 32] = req_word[gi];
  end

  frnd_arbiter #(.NUM_REQ(NUM_REQ), .UNIT_LATENCY(L)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_ready   (resp_ready),
    .unit_execute (unit_execute),
    .unit_in      (unit_in),
    .unit_out     (unit_out),
    .busy         (busy)
`ifdef FRND_ARB_STATS_EN
    ,
    .grant_cnt    (grant_cnt)
`endif
  );

  // Float -> int32, round to nearest even, saturating; NaN reads as +max.
  function automatic logic [31:0] fp_round(input logic [31:0] f);
    logic   s;
    int     e;
    int     sh;
    longint m, q, r, half;
    s = f[31];
    e = int'(f[30:23]);
    m = longint'({1'b1, f[22:0]});
    if (e == 255) return (f[22:0] != 0 || !s) ? 32'h7FFF_FFFF : 32'h8000_0000;
    if (e >= 158) return s ? 32'h8000_0000 : 32'h7FFF_FFFF;
    if (e < 126)  return 32'h0;
    if (e >= 150) begin
      q = m << (e - 150);
    end else begin
      sh   = 150 - e;
      q    = m >> sh;
      r    = m & ((longint'(1) << sh) - 1);
      half = longint'(1) << (sh - 1);
      if (r > half || (r == half && (q % 2) == 1)) q = q + 1;
    end
    if (s) q = -q;
    return 32'(q);
  endfunction

  // Rounding unit: result visible only in cycle T+L for an execute in cycle T.
  logic [31:0] pipe_d [L];
  logic        pipe_v [L];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < L; i++) pipe_v[i] <= 1'b0;
    end else begin
      pipe_v[0] <= unit_execute;
      pipe_d[0] <= fp_round(unit_in);
      for (int i = 1; i < L; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end
  assign unit_out = pipe_v[L-1] ? pipe_d[L-1] : 32'hDEAD_BEEF;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog timeout");
  end

  // ---------------------------------------------------------------------------
  // Transaction-level reference model: idle or busy with one conversion that
  // is offered back L cycles after its grant until the owner accepts it.
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0] exp_req_ready, exp_resp_valid;
  logic               exp_exec, exp_busy;
  logic [31:0]        exp_unit_in, m_exp;
  bit                 m_busy;
  int                 m_left, m_g, m_ptr;
  int                 m_cnt [NUM_REQ];

  function automatic bit bit_of(input logic [NUM_REQ-1:0] v, input int i);
    return 1'(v >> i);
  endfunction

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
    int idx = -1;
    for (int i = 0; i < NUM_REQ; i++) if (bit_of(v, i)) idx = i;
    return idx;
  endfunction

  // Computes this cycle's expected outputs, then advances past the clock edge.
  task automatic model_cycle();
    int  g;
    bit  found;
    exp_req_ready  = '0;
    exp_resp_valid = '0;
    exp_exec       = 1'b0;
    exp_busy       = 1'b0;
    exp_unit_in    = 32'h0;
    if (reset) begin
      m_busy = 1'b0;
      m_ptr  = NUM_REQ - 1;
      for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
    end else if (!m_busy) begin
      found = 1'b0;
      g     = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (!found && bit_of(req_valid, (m_ptr + k) % NUM_REQ)) begin
          found = 1'b1;
          g     = (m_ptr + k) % NUM_REQ;
        end
      end
      if (found) begin
        exp_req_ready = NUM_REQ'(1) << g;
        exp_exec      = 1'b1;
        exp_unit_in   = req_word[g];
        m_busy        = 1'b1;
        m_g           = g;
        m_ptr         = g;
        m_left        = L;
        m_exp         = fp_round(req_word[g]);
        if (m_cnt[g] < 16'hFFFF) m_cnt[g]++;
      end
    end else begin
      exp_busy = 1'b1;
      if (m_left > 0) begin
        m_left--;
      end else begin
        exp_resp_valid = NUM_REQ'(1) << m_g;
        if (bit_of(resp_ready, m_g)) m_busy = 1'b0;
      end
    end
  endtask

  // Inputs are driven at posedge+1 and outputs sampled at posedge+2.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset      = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    repeat (cycles) begin
      tick();
      settle();
      model_cycle();
    end
    reset = 1'b0;
  endtask

  task automatic drain();
    repeat (L + 3) begin
      tick();
      req_valid  = '0;
      resp_ready = '1;
      settle();
    end
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] r = $urandom;
    case ($urandom_range(3))
      0: return {r[31], 8'(126 + $urandom_range(6)), r[22:0]};
      1: return {r[31], 8'(127 + $urandom_range(31)), r[22:0]};
      2: return (r[0]) ? 32'h3FC0_0000 : 32'hBFC0_0000;
      default: return r;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset      = 1'b1;
    req_valid  = '1;
    resp_ready = '1;
    for (int i = 0; i < NUM_REQ; i++) req_word[i] = rand_operand();
    tick();
    settle();
    n_vec++; if (req_ready !== '0) begin n_err++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    n_vec++; if (unit_execute !== 1'b0) begin n_err++; $display("FAIL reset_unit_execute: got %b want 0", unit_execute); end
    n_vec++; if (unit_in !== 32'h0) begin n_err++; $display("FAIL reset_unit_in: got %h want 0", unit_in); end
    n_vec++; if (resp_valid !== '0) begin n_err++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_vec++; if (resp_data !== 32'h0) begin n_err++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    tick();
    req_valid = '0;
    reset     = 1'b0;
    settle();
  endtask

  task automatic test_single();
    logic [31:0] in_v  [4] = '{32'h3FC0_0000, 32'hBFC0_0000, 32'h4010_0000, 32'h5015_02F9};
    logic [31:0] out_v [4] = '{32'h0000_0002, 32'hFFFF_FFFE, 32'h0000_0002, 32'h7FFF_FFFF};
    int lat;
    for (int t = 0; t < 4; t++) begin
      tick();
      req_valid   = 4'b0001;
      req_word[0] = in_v[t];
      resp_ready  = '0;
      settle();
      n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_req_ready[%0d]: got %b want 0001", t, req_ready); end
      n_vec++; if (unit_execute !== 1'b1) begin n_err++; $display("FAIL single_unit_execute[%0d]: got %b want 1", t, unit_execute); end
      n_vec++; if (unit_in !== in_v[t]) begin n_err++; $display("FAIL single_unit_in[%0d]: got %h want %h", t, unit_in, in_v[t]); end
      lat = 0;
      do begin
        tick();
        req_valid  = '0;
        resp_ready = '0;
        settle();
        lat++;
      end while (resp_valid == '0 && lat < 20);
      n_vec++; if (lat != L + 1) begin n_err++; $display("FAIL single_latency[%0d]: got %0d want %0d", t, lat, L + 1); end
      for (int h = 0; h < 3; h++) begin
        n_vec++; if (resp_valid !== 4'b0001) begin n_err++; $display("FAIL single_resp_valid[%0d]: got %b want 0001", t, resp_valid); end
        n_vec++; if (resp_data !== out_v[t]) begin n_err++; $display("FAIL single_resp_data[%0d]: got %h want %h", t, resp_data, out_v[t]); end
        tick();
        resp_ready = (h == 2) ? 4'b0001 : 4'b0000;
        settle();
      end
      tick();
      resp_ready = '0;
      settle();
      n_vec++; if (resp_valid !== '0) begin n_err++; $display("FAIL single_resp_drop[%0d]: got %b want 0", t, resp_valid); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_after[%0d]: got %b want 0", t, busy); end
    end
  endtask

  task automatic test_round_robin();
    int g_idx [$];
    int g_cyc [$];
    int last_g = -1;
    logic [31:0] want;
    do_reset(2);
    for (int i = 0; i < NUM_REQ; i++) req_word[i] = rand_operand();
    for (int c = 0; c < 30; c++) begin
      tick();
      req_valid  = '1;
      resp_ready = '1;
      settle();
      if (req_ready != '0) begin
        last_g = onehot_idx(req_ready);
        g_idx.push_back(last_g);
        g_cyc.push_back(c);
      end
      if (resp_valid != '0 && last_g >= 0) begin
        want = fp_round(req_word[last_g]);
        n_vec++; if (resp_valid !== (NUM_REQ'(1) << last_g)) begin n_err++; $display("FAIL rr_resp_valid: got %b want owner %0d", resp_valid, last_g); end
        n_vec++; if (resp_data !== want) begin n_err++; $display("FAIL rr_resp_data: got %h want %h", resp_data, want); end
      end
    end
    n_vec++;
    if (g_idx.size() < 5) begin
      n_err++; $display("FAIL rr_grant_count: got %0d want >=5", g_idx.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_vec++; if (g_idx[k] != k % NUM_REQ) begin n_err++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, g_idx[k], k % NUM_REQ); end
        if (k > 0) begin
          n_vec++; if (g_cyc[k] - g_cyc[k-1] != L + 2) begin n_err++; $display("FAIL rr_spacing[%0d]: got %0d want %0d", k, g_cyc[k] - g_cyc[k-1], L + 2); end
        end
      end
    end
    drain();
  endtask

  task automatic test_back_pressure();
    logic [31:0] want;
    int k;
    tick();
    req_valid   = 4'b0010;
    req_word[1] = rand_operand();
    req_word[2] = rand_operand();
    resp_ready  = '0;
    settle();
    want = fp_round(req_word[1]);
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_grant1: got %b want 0010", req_ready); end
    tick();
    req_valid = 4'b0100;
    settle();
    k = 0;
    while (resp_valid == '0 && k < 20) begin
      n_vec++; if (req_ready !== '0) begin n_err++; $display("FAIL bp_wait_req_ready: got %b want 0", req_ready); end
      tick();
      settle();
      k++;
    end
    n_vec++; if (k >= 20) begin n_err++; $display("FAIL bp_resp_timeout: got none in %0d cycles want resp_valid", k); end
    for (int h = 0; h < 11; h++) begin
      n_vec++; if (resp_valid !== 4'b0010) begin n_err++; $display("FAIL bp_resp_valid[%0d]: got %b want 0010", h, resp_valid); end
      n_vec++; if (resp_data !== want) begin n_err++; $display("FAIL bp_resp_data[%0d]: got %h want %h", h, resp_data, want); end
      n_vec++; if (req_ready !== '0) begin n_err++; $display("FAIL bp_req_ready[%0d]: got %b want 0", h, req_ready); end
      n_vec++; if (unit_execute !== 1'b0) begin n_err++; $display("FAIL bp_unit_execute[%0d]: got %b want 0", h, unit_execute); end
      if (h < 10) begin
        tick();
        resp_ready = 4'b1101;
        settle();
      end
    end
    resp_ready = 4'b0010;
    settle();
    n_vec++; if (req_ready !== '0) begin n_err++; $display("FAIL bp_handshake_req_ready: got %b want 0", req_ready); end
    tick();
    resp_ready = '0;
    settle();
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL bp_grant2: got %b want 0100", req_ready); end
    n_vec++; if (unit_execute !== 1'b1) begin n_err++; $display("FAIL bp_grant2_execute: got %b want 1", unit_execute); end
    n_vec++; if (unit_in !== req_word[2]) begin n_err++; $display("FAIL bp_grant2_unit_in: got %h want %h", unit_in, req_word[2]); end
    drain();
  endtask

  task automatic test_reset_mid_wait();
    tick();
    req_valid   = 4'b1000;
    req_word[3] = rand_operand();
    resp_ready  = '0;
    settle();
    n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL rmw_grant3: got %b want 1000", req_ready); end
    tick();
    req_valid = '0;
    settle();
    tick();
    reset     = 1'b1;
    req_valid = '1;
    settle();
    n_vec++; if (req_ready !== '0) begin n_err++; $display("FAIL rmw_req_ready: got %b want 0", req_ready); end
    n_vec++; if (unit_execute !== 1'b0) begin n_err++; $display("FAIL rmw_unit_execute: got %b want 0", unit_execute); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmw_busy: got %b want 0", busy); end
    n_vec++; if (resp_valid !== '0) begin n_err++; $display("FAIL rmw_resp_valid: got %b want 0", resp_valid); end
    tick();
    reset     = 1'b0;
    req_valid = '0;
    settle();
    for (int c = 0; c < L + 3; c++) begin
      n_vec++; if (resp_valid !== '0) begin n_err++; $display("FAIL rmw_no_resp[%0d]: got %b want 0", c, resp_valid); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmw_idle[%0d]: got %b want 0", c, busy); end
      tick();
      settle();
    end
    req_valid = '1;
    settle();
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rmw_first_grant: got %b want 0001", req_ready); end
    drain();
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] granted_prev = '0;
    logic [NUM_REQ-1:0] nv;
    do_reset(2);
    for (int c = 0; c < 2500; c++) begin
      tick();
      nv = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bit_of(req_valid, i) && !bit_of(granted_prev, i)) begin
          if ($urandom_range(7) != 0) nv |= NUM_REQ'(1) << i;
        end else begin
          if ($urandom_range(1) == 0) nv |= NUM_REQ'(1) << i;
          req_word[i] = rand_operand();
        end
      end
      req_valid  = nv;
      resp_ready = NUM_REQ'($urandom);
      reset      = ($urandom_range(299) == 0);
      settle();
      model_cycle();
      granted_prev = exp_req_ready;
      n_vec++; if (req_ready !== exp_req_ready) begin n_err++; $display("FAIL rnd_req_ready@%0d: got %b want %b", c, req_ready, exp_req_ready); end
      n_vec++; if (unit_execute !== exp_exec) begin n_err++; $display("FAIL rnd_unit_execute@%0d: got %b want %b", c, unit_execute, exp_exec); end
      n_vec++; if (unit_in !== exp_unit_in) begin n_err++; $display("FAIL rnd_unit_in@%0d: got %h want %h", c, unit_in, exp_unit_in); end
      n_vec++; if (resp_valid !== exp_resp_valid) begin n_err++; $display("FAIL rnd_resp_valid@%0d: got %b want %b", c, resp_valid, exp_resp_valid); end
      n_vec++; if (busy !== exp_busy) begin n_err++; $display("FAIL rnd_busy@%0d: got %b want %b", c, busy, exp_busy); end
      if (exp_resp_valid != '0) begin
        n_vec++; if (resp_data !== m_exp) begin n_err++; $display("FAIL rnd_resp_data@%0d: got %h want %h", c, resp_data, m_exp); end
      end
    end
    reset = 1'b0;
    drain();
  endtask

`ifdef FRND_ARB_STATS_EN
  task automatic test_stats();
    do_reset(2);
    n_vec++; if (grant_cnt !== '0) begin n_err++; $display("FAIL stats_reset: got %h want 0", grant_cnt); end
    for (int n = 0; n < 3; n++) begin
      tick();
      req_valid   = 4'b0100;
      req_word[2] = rand_operand();
      resp_ready  = '1;
      settle();
      tick();
      req_valid = '0;
      settle();
      repeat (L + 2) begin
        tick();
        settle();
      end
    end
    n_vec++; if (grant_cnt[47:32] !== 16'd3) begin n_err++; $display("FAIL stats_cnt2: got %0d want 3", grant_cnt[47:32]); end
    n_vec++; if (grant_cnt[15:0] !== 16'd0) begin n_err++; $display("FAIL stats_cnt0: got %0d want 0", grant_cnt[15:0]); end
  endtask
`endif

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) req_word[i] = 32'h0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_reset_mid_wait();
    test_random();
`ifdef FRND_ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
